// File: rtl/rv_plic_pkg.sv
// Shared widths, types and helpers for the PLIC per-target arbitration slice.
package rv_plic_pkg;

    localparam int N_SOURCE = 32;
    localparam int MAX_PRIO = 7;
    localparam int PRIOW    = $clog2(MAX_PRIO + 1);
    localparam int SRCW     = $clog2(N_SOURCE);

    typedef logic [PRIOW-1:0] prio_t;
    typedef logic [SRCW-1:0]  id_t;

    function automatic logic [N_SOURCE-1:0] id_onehot(id_t id);
        logic [N_SOURCE-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rv_plic_prio_tree.sv
// Combinational max-tree over (priority, index) pairs; ties resolve to the lowest index.
module rv_plic_prio_tree #(
    parameter int N     = 32,
    parameter int PRIOW = 3,
    parameter int IDW   = 5
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PRIOW-1:0] prio_i [N],
    output logic             valid_o,
    output logic [PRIOW-1:0] prio_o,
    output logic [IDW-1:0]   id_o
);

    localparam int NP    = 2 ** $clog2(N);
    localparam int NODES = 2 * NP - 1;

    // Heap layout: node k has children 2k+1 (lower indices) and 2k+2; leaves start at NP-1.
    logic             node_v  [NODES];
    logic [PRIOW-1:0] node_p  [NODES];
    logic [IDW-1:0]   node_id [NODES];

    always_comb begin
        for (int k = 0; k < NODES; k++) begin
            node_v[k]  = 1'b0;
            node_p[k]  = '0;
            node_id[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            node_v[NP-1+i]  = valid_i[i];
            node_p[NP-1+i]  = prio_i[i];
            node_id[NP-1+i] = IDW'(i);
        end
        // Left wins on equal priority, which yields the lowest-index tie-break.
        for (int k = NP - 2; k >= 0; k--) begin
            if (node_v[2*k+1] && (!node_v[2*k+2] || node_p[2*k+1] >= node_p[2*k+2])) begin
                node_v[k]  = node_v[2*k+1];
                node_p[k]  = node_p[2*k+1];
                node_id[k] = node_id[2*k+1];
            end else begin
                node_v[k]  = node_v[2*k+2];
                node_p[k]  = node_p[2*k+2];
                node_id[k] = node_id[2*k+2];
            end
        end
    end

    assign valid_o = node_v[0];
    assign prio_o  = node_p[0];
    assign id_o    = node_id[0];

endmodule

// File: rtl/rv_plic_target_arb.sv
// Per-target PLIC stage: masks pending sources, registers the winning ID and
// turns claim reads / complete writes into one-hot gateway pulses.
module rv_plic_target_arb #(
    parameter int N_SOURCE = rv_plic_pkg::N_SOURCE,
    parameter int MAX_PRIO = rv_plic_pkg::MAX_PRIO,
    parameter int PRIOW    = $clog2(MAX_PRIO + 1),
    parameter int SRCW     = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] ip_i,
    input  logic [N_SOURCE-1:0] ie_i,
    input  logic [PRIOW-1:0]    prio_i [N_SOURCE],
    input  logic [PRIOW-1:0]    threshold_i,
    input  logic                claim_re_i,
    output logic [SRCW-1:0]     claim_id_o,
    input  logic                complete_we_i,
    input  logic [SRCW-1:0]     complete_id_i,
    output logic                irq_o,
    output logic [SRCW-1:0]     irq_id_o,
    output logic [N_SOURCE-1:0] claim_o,
    output logic [N_SOURCE-1:0] complete_o
);

    logic                irq_q;
    logic [SRCW-1:0]     irq_id_q;
    logic [N_SOURCE-1:0] outstanding_q;
    logic [N_SOURCE-1:0] cand;
    logic                win_valid;
    logic [PRIOW-1:0]    win_prio;
    logic [SRCW-1:0]     win_id;
    logic                win_irq;

    // Masking with claim_o keeps the just-claimed ID out of the next registered winner.
    always_comb begin
        cand       = '0;
        claim_o    = '0;
        complete_o = '0;
        for (int i = 0; i < N_SOURCE; i++) begin
            claim_o[i]    = (i != 0) && claim_re_i && (irq_id_q == SRCW'(i));
            complete_o[i] = (i != 0) && complete_we_i && (complete_id_i == SRCW'(i))
                            && outstanding_q[i];
            cand[i]       = (i != 0) && ip_i[i] && ie_i[i] && !claim_o[i];
        end
    end

    rv_plic_prio_tree #(
        .N     (N_SOURCE),
        .PRIOW (PRIOW),
        .IDW   (SRCW)
    ) u_prio_tree (
        .valid_i (cand),
        .prio_i  (prio_i),
        .valid_o (win_valid),
        .prio_o  (win_prio),
        .id_o    (win_id)
    );

    // Threshold applied once at the root: the max exceeds it iff some candidate does,
    // and the max is then that candidate with the same tie-break.
    assign win_irq = win_valid && (win_prio > threshold_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q         <= 1'b0;
            irq_id_q      <= '0;
            outstanding_q <= '0;
        end else begin
            irq_q         <= win_irq;
            irq_id_q      <= win_irq ? win_id : '0;
            outstanding_q <= (outstanding_q & ~complete_o) | claim_o;
        end
    end

    assign irq_o      = irq_q;
    assign irq_id_o   = irq_id_q;
    assign claim_id_o = irq_id_q;

endmodule

// File: tb/tb_rv_plic_target_arb.sv
// Directed scoreboard bench for rv_plic_target_arb.
module tb_rv_plic_target_arb;
    import rv_plic_pkg::*;

    localparam int N  = N_SOURCE;
    localparam int SW = SRCW;
    localparam int EW = 1 + 2 * SW + 2 * N;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  ip;
    logic [N-1:0]  ie;
    prio_t         prio [N];
    prio_t         thr;
    logic          claim_re;
    id_t           claim_id;
    logic          complete_we;
    id_t           complete_id;
    logic          irq;
    id_t           irq_id;
    logic [N-1:0]  claim;
    logic [N-1:0]  complete;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec;
    int            n_err;

    rv_plic_target_arb dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ip_i          (ip),
        .ie_i          (ie),
        .prio_i        (prio),
        .threshold_i   (thr),
        .claim_re_i    (claim_re),
        .claim_id_o    (claim_id),
        .complete_we_i (complete_we),
        .complete_id_i (complete_id),
        .irq_o         (irq),
        .irq_id_o      (irq_id),
        .claim_o       (claim),
        .complete_o    (complete)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
        claim_re    = 1'b0;
        complete_we = 1'b0;
        complete_id = '0;
    endtask

    task automatic chk(input string name, input logic e_irq, input int e_id, input int e_cid,
                       input logic [N-1:0] e_claim, input logic [N-1:0] e_comp);
        exp_q.push_back({e_irq, SW'(e_id), SW'(e_cid), e_claim, e_comp});
        name_q.push_back(name);
    endtask

    task automatic do_complete(input int id);
        complete_we = 1'b1;
        complete_id = SW'(id);
    endtask

    // scoreboard monitor: compares every queued expectation against the outputs at negedge
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            string         nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {irq, irq_id, claim_id, claim, complete};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got irq=%0d id=%0d cid=%0d claim=%h complete=%h, want irq=%0d id=%0d cid=%0d claim=%h complete=%h",
                         nm, a[EW-1], a[EW-2 -: SW], a[EW-2-SW -: SW], a[2*N-1 -: N], a[N-1:0],
                         e[EW-1], e[EW-2 -: SW], e[EW-2-SW -: SW], e[2*N-1 -: N], e[N-1:0]);
            end
        end
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        ip          = '0;
        ie          = '0;
        thr         = '0;
        claim_re    = 1'b0;
        complete_we = 1'b0;
        complete_id = '0;
        for (int i = 0; i < N; i++) prio[i] = '0;

        repeat (2) next_cycle();
        claim_re = 1'b1;
        do_complete(5);
        chk("reset_held", 0, 0, 0, '0, '0);
        next_cycle();
        rst_n = 1'b1;
        chk("reset_idle", 0, 0, 0, '0, '0);
        next_cycle();
        claim_re = 1'b1;
        chk("idle_claim", 0, 0, 0, '0, '0);

        // priority and tie-break
        next_cycle();
        ie      = '1;
        prio[3] = 3'd2;
        prio[5] = 3'd6;
        prio[9] = 3'd6;
        thr     = 3'd1;
        ip[3]   = 1'b1;
        ip[5]   = 1'b1;
        ip[9]   = 1'b1;
        chk("one_cycle_latency", 0, 0, 0, '0, '0);
        next_cycle();
        chk("prio_tie_low_index", 1, 5, 5, '0, '0);
        thr = 3'd6;
        next_cycle();
        chk("threshold_strict", 0, 0, 0, '0, '0);
        thr = 3'd1;

        // claim and stale-winner suppression
        next_cycle();
        claim_re = 1'b1;
        chk("claim_first", 1, 5, 5, id_onehot(id_t'(5)), '0);
        next_cycle();
        ip[5]    = 1'b0;
        claim_re = 1'b1;
        chk("claim_second", 1, 9, 9, id_onehot(id_t'(9)), '0);
        next_cycle();
        ip[9] = 1'b0;
        chk("after_two_claims", 1, 3, 3, '0, '0);
        ip[3] = 1'b0;
        next_cycle();
        claim_re = 1'b1;
        chk("empty_claim", 0, 0, 0, '0, '0);

        // complete filtering
        next_cycle();
        do_complete(5);
        chk("complete_5", 0, 0, 0, '0, id_onehot(id_t'(5)));
        next_cycle();
        do_complete(5);
        chk("complete_5_repeat", 0, 0, 0, '0, '0);
        next_cycle();
        do_complete(7);
        chk("complete_7_unclaimed", 0, 0, 0, '0, '0);
        next_cycle();
        do_complete(0);
        chk("complete_0", 0, 0, 0, '0, '0);
        next_cycle();
        do_complete(9);
        chk("complete_9", 0, 0, 0, '0, id_onehot(id_t'(9)));

        // claim and complete of the same ID in one cycle
        next_cycle();
        ip[3] = 1'b1;
        chk("lat_src3", 0, 0, 0, '0, '0);
        next_cycle();
        claim_re = 1'b1;
        do_complete(3);
        chk("claim_complete_same", 1, 3, 3, id_onehot(id_t'(3)), '0);
        next_cycle();
        ip[3] = 1'b0;
        do_complete(3);
        chk("complete_3_after", 0, 0, 0, '0, id_onehot(id_t'(3)));

        // claim and complete of different IDs in one cycle
        next_cycle();
        ip[5] = 1'b1;
        ip[9] = 1'b1;
        chk("lat_src59", 0, 0, 0, '0, '0);
        next_cycle();
        claim_re = 1'b1;
        chk("claim_5_again", 1, 5, 5, id_onehot(id_t'(5)), '0);
        next_cycle();
        ip[5]    = 1'b0;
        ip[3]    = 1'b1;
        claim_re = 1'b1;
        do_complete(5);
        chk("claim9_complete5", 1, 9, 9, id_onehot(id_t'(9)), id_onehot(id_t'(5)));
        next_cycle();
        ip[9] = 1'b0;
        chk("pre_reset", 1, 3, 3, '0, '0);

        // asynchronous reset between edges with ID 9 outstanding
        next_cycle();
        rst_n    = 1'b0;
        claim_re = 1'b1;
        do_complete(9);
        chk("async_reset", 0, 0, 0, '0, '0);
        next_cycle();
        rst_n = 1'b1;
        ip    = '0;
        do_complete(9);
        chk("complete_after_reset", 0, 0, 0, '0, '0);
        next_cycle();
        do_complete(9);
        chk("final_idle", 0, 0, 0, '0, '0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
